jk_bank_sched: RTL and testbench

- Scheduler and owner of a bank of WIDTH master-slave JK flip-flops shared by NREQ requesters.
- Each requester posts one command (hold/reset/set/toggle) against one bit of the bank.
- A round-robin arbiter picks one command at a time. A 3-state FSM then sequences it through a master phase (J/K driven, master captures) and a slave phase (Q updates), emulating master-slave JK timing on a single clock.
- Sits between control logic that wants to manipulate individual flag bits and the flop bank itself.

---
 rtl/jk_bank_sched.sv | 190 +++++++++++++++++++
 tb/tb_jk_bank_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler owning a bank of master-slave JK flip-flops.
// Each command runs IDLE -> DRIVE (master captures) -> COMMIT (slave/q updates).
module jk_bank_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [IDXW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [WIDTH-1:0]       j,
  output logic [WIDTH-1:0]       k,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic                   busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     win_q, win_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  master_q, master_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  q_bar_q, q_bar_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic [1:0]        new_op;
  logic [IDXW-1:0]   new_idx;
  logic [WIDTH-1:0]  new_sel;
  logic [WIDTH-1:0]  cur_sel;
  logic [WIDTH-1:0]  jk_next;

  // One-hot decode of a bit index; out-of-range indices decode to zero.
  function automatic logic [WIDTH-1:0] bit_sel(input logic [IDXW-1:0] ix);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (32'(ix) == b) s[b] = 1'b1;
    end
    return s;
  endfunction

  // Round-robin pick: first pass from the pointer upward, second pass wraps.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    new_op  = '0;
    new_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= 32'(ptr_q))) begin
        found   = 1'b1;
        pick    = PW'(i);
        new_op  = op[2*i +: 2];
        new_idx = idx[IDXW*i +: IDXW];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        pick    = PW'(i);
        new_op  = op[2*i +: 2];
        new_idx = idx[IDXW*i +: IDXW];
      end
    end
  end

  assign new_sel = bit_sel(new_idx);
  assign cur_sel = bit_sel(idx_q);

  // JK characteristic applied across the whole word; cur_sel picks the bit.
  always_comb begin
    jk_next = q_q;
    case (op_q)
      2'b01:   jk_next = '0;
      2'b10:   jk_next = '1;
      2'b11:   jk_next = ~q_q;
      default: jk_next = q_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    idx_d    = idx_q;
    master_d = master_q;
    q_d      = q_q;
    j_d      = '0;
    k_d      = '0;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = DRIVE;
          win_d   = pick;
          op_d    = new_op;
          idx_d   = new_idx;
          gnt_d   = NREQ'(1) << pick;
          j_d     = new_op[1] ? new_sel : '0;
          k_d     = new_op[0] ? new_sel : '0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        state_d  = COMMIT;
        busy_d   = 1'b1;
        master_d = (master_q & ~cur_sel) | (jk_next & cur_sel);
      end
      COMMIT: begin
        state_d = IDLE;
        q_d     = (q_q & ~cur_sel) | (master_q & cur_sel);
        done_d  = NREQ'(1) << win_q;
        err_d   = ~|cur_sel;
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign q_bar_d = ~q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      ptr_q    <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      master_q <= '0;
      q_q      <= '0;
      q_bar_q  <= '1;
      j_q      <= '0;
      k_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      master_q <= master_d;
      q_q      <= q_d;
      q_bar_q  <= q_bar_d;
      j_q      <= j_d;
      k_q      <= k_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign j     = j_q;
  assign k     = k_q;
  assign q     = q_q;
  assign q_bar = q_bar_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: two instances (WIDTH 8 and 6) share stimulus and are
// checked against a transaction-level model of the bank and round-robin pointer.
module tb_jk_bank_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;

  logic [NREQ-1:0] gnt_a, done_a, gnt_b, done_b;
  logic            err_a, err_b, busy_a, busy_b;
  logic [7:0]      j_a, k_a, q_a, qb_a;
  logic [5:0]      j_b, k_b, q_b, qb_b;

  jk_bank_sched #(.NREQ(NREQ), .WIDTH(8), .IDXW(IDXW)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt_a), .done(done_a), .err(err_a), .j(j_a), .k(k_a),
    .q(q_a), .q_bar(qb_a), .busy(busy_a)
  );

  jk_bank_sched #(.NREQ(NREQ), .WIDTH(6), .IDXW(IDXW)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt_b), .done(done_b), .err(err_b), .j(j_b), .k(k_b),
    .q(q_b), .q_bar(qb_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bank contents per instance, pointer, pending commands.
  logic [7:0]      mq [2];
  int              ptr;
  logic [NREQ-1:0] pend;
  logic [1:0]      mop  [NREQ];
  int              midx [NREQ];

  function automatic int wd(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [7:0] wmask(input int d);
    return (d == 0) ? 8'hFF : 8'h3F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                      input logic [31:0] ea, input logic [31:0] eb);
    check({tag, "_w8"}, oa, ea);
    check({tag, "_w6"}, ob, eb);
  endtask

  task automatic post(input int r, input logic [1:0] o, input int ix);
    pend[r] = 1'b1;
    mop[r]  = o;
    midx[r] = ix;
    req[r]  = 1'b1;
    op[2*r +: 2]       = o;
    idx[IDXW*r +: IDXW] = IDXW'(ix);
  endtask

  task automatic model_reset();
    mq[0] = '0;
    mq[1] = '0;
    ptr   = 0;
    pend  = '0;
    req   = '0;
  endtask

  // Runs one full command from an IDLE negedge; returns the model's winner.
  task automatic serve_one(output int w);
    logic [7:0] ej [2];
    logic [7:0] ek [2];
    logic [7:0] bitv;
    logic       b;
    w = -1;
    for (int s = 0; s < int'(NREQ); s++) begin
      int c;
      c = (ptr + s) % int'(NREQ);
      if (w < 0 && pend[c]) w = c;
    end
    if (w < 0) return;

    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bitv  = (midx[w] < wd(d)) ? 8'(1 << midx[w]) : 8'h00;
      ej[d] = mop[w][1] ? bitv : 8'h00;
      ek[d] = mop[w][0] ? bitv : 8'h00;
    end
    chk2("drv_gnt",  gnt_a,  gnt_b,  32'(1 << w), 32'(1 << w));
    chk2("drv_busy", busy_a, busy_b, 1, 1);
    chk2("drv_j",    j_a,    j_b,    ej[0], ej[1]);
    chk2("drv_k",    k_a,    k_b,    ek[0], ek[1]);
    chk2("drv_q",    q_a,    q_b,    mq[0], mq[1]);
    chk2("drv_done", done_a, done_b, 0, 0);
    pend[w] = 1'b0;
    req[w]  = 1'b0;

    @(negedge clk);
    chk2("cmt_gnt",  gnt_a,  gnt_b,  0, 0);
    chk2("cmt_busy", busy_a, busy_b, 1, 1);
    chk2("cmt_jk",   {j_a, k_a}, {j_b, k_b}, 0, 0);
    chk2("cmt_q",    q_a,    q_b,    mq[0], mq[1]);

    for (int d = 0; d < 2; d++) begin
      if (midx[w] < wd(d)) begin
        b = mq[d][midx[w]];
        case (mop[w])
          2'b01:   b = 1'b0;
          2'b10:   b = 1'b1;
          2'b11:   b = ~b;
          default: b = b;
        endcase
        mq[d][midx[w]] = b;
      end
    end
    ptr = (w + 1) % int'(NREQ);

    @(negedge clk);
    chk2("idl_q",    q_a,    q_b,    mq[0], mq[1]);
    chk2("idl_qbar", qb_a,   qb_b,   ~mq[0] & wmask(0), ~mq[1] & wmask(1));
    chk2("idl_done", done_a, done_b, 32'(1 << w), 32'(1 << w));
    chk2("idl_err",  err_a,  err_b,  32'(midx[w] >= 8), 32'(midx[w] >= 6));
    chk2("idl_busy", busy_a, busy_b, 0, 0);
  endtask

  task automatic run_all();
    int w;
    int n;
    n = 0;
    while (pend != '0 && n < 4 * int'(NREQ)) begin
      serve_one(w);
      n++;
    end
    check("drain", 32'(pend), 0);
  endtask

  int w;
  int exp_ord [3];

  initial begin
    rst = 1'b1;
    op  = '0;
    idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk2("rst_q",    q_a,    q_b,    0, 0);
    chk2("rst_qbar", qb_a,   qb_b,   8'hFF, 6'h3F);
    chk2("rst_out",  {gnt_a, done_a, err_a, busy_a}, {gnt_b, done_b, err_b, busy_b}, 0, 0);
    chk2("rst_jk",   {j_a, k_a}, {j_b, k_b}, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin from pointer 0: everyone sets its own bit.
    for (int i = 0; i < 4; i++) post(i, 2'b10, i);
    for (int i = 0; i < 4; i++) begin
      serve_one(w);
      check("rr_order", 32'(w), 32'(i));
    end
    check("rr_q", 32'(q_a), 32'h0F);

    // Reset in the middle of DRIVE discards the command.
    post(0, 2'b10, 2);
    @(posedge clk);
    @(negedge clk);
    chk2("pre_rst_busy", busy_a, busy_b, 1, 1);
    rst = 1'b1;
    #1;
    chk2("async_q",    q_a,   q_b,   0, 0);
    chk2("async_qbar", qb_a,  qb_b,  8'hFF, 6'h3F);
    chk2("async_gnt",  gnt_a, gnt_b, 0, 0);
    chk2("async_busy", busy_a, busy_b, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk2("post_rst_done", done_a, done_b, 0, 0);
      chk2("post_rst_q",    q_a,    q_b,    0, 0);
    end

    // Op sequence on bit 3 from requester 0.
    post(0, 2'b10, 3); serve_one(w); check("seq_set",  32'(q_a), 32'h08);
    post(0, 2'b01, 3); serve_one(w); check("seq_rst",  32'(q_a), 32'h00);
    post(0, 2'b11, 3); serve_one(w); check("seq_tgl1", 32'(q_a), 32'h08);
    post(0, 2'b11, 3); serve_one(w); check("seq_tgl2", 32'(q_a), 32'h00);
    post(0, 2'b00, 3); serve_one(w); check("seq_hold", 32'(q_a), 32'h00);

    // Fairness after wrap: move pointer to 2, then req=1011.
    post(1, 2'b00, 0);
    serve_one(w);
    post(0, 2'b10, 5);
    post(1, 2'b10, 4);
    post(3, 2'b10, 1);
    exp_ord = '{3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      serve_one(w);
      check("fair_order", 32'(w), 32'(exp_ord[i]));
    end

    // Idx 7 is out of range for the 6-bit bank, in range for the 8-bit one.
    post(1, 2'b10, 7);
    serve_one(w);

    // Isolation: build 0x5A, then toggle bit 0.
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post(2, 2'b10, 1); serve_one(w);
    post(2, 2'b10, 3); serve_one(w);
    post(2, 2'b10, 4); serve_one(w);
    post(2, 2'b10, 6); serve_one(w);
    check("iso_start", 32'(q_a), 32'h5A);
    post(0, 2'b11, 0);
    serve_one(w);
    chk2("iso_q",    q_a,  q_b,  8'h5B, 6'h1B);
    chk2("iso_qbar", qb_a, qb_b, 8'hA4, 6'h24);

    // Randomized bursts of simultaneous requests.
    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (m[i]) post(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      end
      run_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
